// File: rtl/alt_vipcto131_common_sample_serializer.sv
// Output-side sample serializer: holds one parallel pixel sample and sends it downstream
// either one colour plane per beat (SD) or the whole sample in one beat (HD).
module alt_vipcto131_common_sample_serializer #(
    parameter int NUMBER_OF_COLOUR_PLANES      = 3,
    parameter int LOG2_NUMBER_OF_COLOUR_PLANES = 2,
    parameter int BPS                          = 8
) (
    input  logic                                      clk,
    input  logic                                      rst_n,
    input  logic                                      sclr,
    input  logic                                      hd_sdn,
    input  logic [NUMBER_OF_COLOUR_PLANES*BPS-1:0]    din_data,
    input  logic                                      din_valid,
    output logic                                      din_ready,
    output logic [NUMBER_OF_COLOUR_PLANES*BPS-1:0]    dout_data,
    output logic                                      dout_valid,
    input  logic                                      dout_ready,
    output logic                                      start_of_sample,
    output logic                                      end_of_sample,
    output logic [LOG2_NUMBER_OF_COLOUR_PLANES-1:0]   plane_ticks
);

    localparam int N  = NUMBER_OF_COLOUR_PLANES;
    localparam int LW = LOG2_NUMBER_OF_COLOUR_PLANES;
    localparam int W  = N * BPS;

    // Select colour plane idx out of a packed sample.
    function automatic logic [BPS-1:0] plane_sel(input logic [W-1:0] smp, input logic [LW-1:0] idx);
        logic [BPS-1:0] res;
        res = '0;
        for (int k = 0; k < N; k++) begin
            if (int'(idx) == k) begin
                res = smp[k*BPS +: BPS];
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    function automatic logic is_last_idx(input logic [LW-1:0] idx);
        return (int'(idx) == (N - 1));
    endfunction

    logic [W-1:0]  sample_q, sample_d;
    logic          hd_q, hd_d;
    logic          full_q, full_d;
    logic [LW-1:0] cnt_q, cnt_d;

    logic [W-1:0]  dout_data_q, dout_data_d;
    logic          sos_q, sos_d;
    logic          eos_q, eos_d;
    logic [LW-1:0] plane_q, plane_d;

    logic last_s;
    logic fire_out_s;
    logic ready_core_s;
    logic accept_s;

    // Handshake decode from the registered state.
    always_comb begin
        last_s       = full_q & (hd_q | is_last_idx(cnt_q));
        fire_out_s   = full_q & dout_ready;
        ready_core_s = ~sclr & (~full_q | (dout_ready & last_s));
        accept_s     = din_valid & ready_core_s;
    end

    // rst_n only masks the output port; the internal accept path never needs it because
    // every flop is held in reset while rst_n is low.
    assign din_ready = rst_n & ready_core_s;

    // Next-state for the hold register and plane counter.
    always_comb begin
        sample_d = sample_q;
        hd_d     = hd_q;
        full_d   = full_q;
        cnt_d    = cnt_q;
        if (sclr) begin
            sample_d = '0;
            hd_d     = 1'b0;
            full_d   = 1'b0;
            cnt_d    = '0;
        end else if (accept_s) begin
            sample_d = din_data;
            hd_d     = hd_sdn;
            full_d   = 1'b1;
            cnt_d    = '0;
        end else if (fire_out_s && !last_s) begin
            cnt_d = cnt_q + LW'(1'b1);
        end else if (fire_out_s) begin
            full_d = 1'b0;
            cnt_d  = '0;
        end else begin
            sample_d = sample_q;
            cnt_d    = cnt_q;
        end
    end

    // Output values are derived from next state so the ports come straight from flops.
    always_comb begin
        dout_data_d = '0;
        if (full_d) begin
            if (hd_d) begin
                dout_data_d = sample_d;
            end else begin
                dout_data_d[BPS-1:0] = plane_sel(sample_d, cnt_d);
            end
        end else begin
            dout_data_d = '0;
        end
        sos_d   = full_d & (cnt_d == '0);
        eos_d   = full_d & (hd_d | is_last_idx(cnt_d));
        plane_d = hd_d ? '0 : cnt_d;
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sample_q    <= '0;
            hd_q        <= 1'b0;
            full_q      <= 1'b0;
            cnt_q       <= '0;
            dout_data_q <= '0;
            sos_q       <= 1'b0;
            eos_q       <= 1'b0;
            plane_q     <= '0;
        end else begin
            sample_q    <= sample_d;
            hd_q        <= hd_d;
            full_q      <= full_d;
            cnt_q       <= cnt_d;
            dout_data_q <= dout_data_d;
            sos_q       <= sos_d;
            eos_q       <= eos_d;
            plane_q     <= plane_d;
        end
    end

    assign dout_valid      = full_q;
    assign dout_data       = dout_data_q;
    assign start_of_sample = sos_q;
    assign end_of_sample   = eos_q;
    assign plane_ticks     = plane_q;

endmodule
